// File: rtl/contar_bombas.sv
// contar_bombas: Minesweeper neighbour-count engine.
// Each input cell equal to BOMB is a bomb. Each output cell is BOMB for a bomb,
// or the number of bombs among its up-to-8 neighbours (0..8), registered once per clock.
// Ports:
//   clk             - system clock, rising edge
//   rst             - asynchronous active-low reset, clears the output board
//   matrizBombastic - input board  [ROWS][COLS][CELL_W]
//   matrizNumeros   - registered output board, same indexing
module contar_bombas #(
  parameter int unsigned       ROWS   = 8,
  parameter int unsigned       COLS   = 8,
  parameter int unsigned       CELL_W = 4,
  parameter logic [CELL_W-1:0] BOMB   = CELL_W'(4'hF)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [ROWS-1:0][COLS-1:0][CELL_W-1:0] matrizBombastic,
  output logic [ROWS-1:0][COLS-1:0][CELL_W-1:0] matrizNumeros
);

  // Bomb map with a one-cell border of zeros so edge cells need no bounds checks.
  localparam int unsigned PAD_ROWS = ROWS + 2;
  localparam int unsigned PAD_COLS = COLS + 2;

  logic [PAD_ROWS-1:0][PAD_COLS-1:0]     mapaBombas;
  logic [ROWS-1:0][COLS-1:0][CELL_W-1:0] siguiente;

  // Flag bombs into the padded map; the border stays empty.
  always_comb begin
    mapaBombas = '0;
    for (int i = 0; i < int'(ROWS); i++) begin
      for (int j = 0; j < int'(COLS); j++) begin
        mapaBombas[i+1][j+1] = (matrizBombastic[i][j] == BOMB);
      end
    end
  end

  // Per-cell next value: BOMB for bombs, otherwise the 3x3 window count minus the centre.
  always_comb begin
    siguiente = '0;
    for (int i = 0; i < int'(ROWS); i++) begin
      for (int j = 0; j < int'(COLS); j++) begin
        if (mapaBombas[i+1][j+1]) begin
          siguiente[i][j] = BOMB;
        end else begin
          for (int di = 0; di < 3; di++) begin
            for (int dj = 0; dj < 3; dj++) begin
              if (!(di == 1 && dj == 1)) begin
                siguiente[i][j] = siguiente[i][j] + CELL_W'(mapaBombas[i+di][j+dj]);
              end
            end
          end
        end
      end
    end
  end

  // Whole board registered on every edge; async reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      matrizNumeros <= '0;
    end else begin
      matrizNumeros <= siguiente;
    end
  end

endmodule

// File: tb/tb_contar_bombas.sv
// tb_contar_bombas: randomized and directed checks of contar_bombas against a
// behavioural neighbour-count model over an integer board.
module tb_contar_bombas;

  logic                   clk;
  logic                   rst;
  logic [7:0][7:0][3:0]   matrizBombastic;
  logic [7:0][7:0][3:0]   matrizNumeros;

  int board [8][8];
  int nChecks = 0;
  int nPass   = 0;

  contar_bombas dut (
    .clk             (clk),
    .rst             (rst),
    .matrizBombastic (matrizBombastic),
    .matrizNumeros   (matrizNumeros)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [255:0] packBoard();
    logic [255:0] v = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        v[(r*8+c)*4 +: 4] = 4'(board[r][c]);
    return v;
  endfunction

  // Reference: bomb stays 15, else count in-range neighbours equal to 15.
  function automatic logic [255:0] modelo();
    logic [255:0] v = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        int n = 0;
        if (board[r][c] == 15) n = 15;
        else begin
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
              if ((dr != 0 || dc != 0) && r+dr >= 0 && r+dr < 8 && c+dc >= 0 && c+dc < 8
                  && board[r+dr][c+dc] == 15) n++;
        end
        v[(r*8+c)*4 +: 4] = 4'(n);
      end
    end
    return v;
  endfunction

  task automatic clearBoard(input int val);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        board[r][c] = val;
  endtask

  // Drive at the falling edge, register at the rising edge, sample 1 time unit later.
  task automatic applyAndCheck(input string tag);
    @(negedge clk);
    matrizBombastic = packBoard();
    @(posedge clk);
    #1;
    checkVal(tag, matrizNumeros, modelo());
  endtask

  logic [31:0]  mixedRows [8];
  logic [255:0] expMixed;
  logic [255:0] boardA;

  initial begin
    rst = 1'b0;
    clearBoard(15);
    matrizBombastic = packBoard();

    // Reset held: output stays zero across edges.
    repeat (3) @(posedge clk);
    #1;
    checkVal("reset_hold", matrizNumeros, 256'd0);
    @(negedge clk);
    rst = 1'b1;

    // Mixed board against hand-derived rows (cell j at bits j*4 of each row word).
    mixedRows[0] = 32'h0000112F;
    mixedRows[1] = 32'h00001F32;
    mixedRows[2] = 32'h000012F1;
    mixedRows[3] = 32'h00000111;
    mixedRows[4] = 32'h00000000;
    mixedRows[5] = 32'h00111000;
    mixedRows[6] = 32'h001F1000;
    mixedRows[7] = 32'h00111000;
    for (int r = 0; r < 8; r++) expMixed[r*32 +: 32] = mixedRows[r];
    clearBoard(0);
    board[0][0] = 15; board[1][2] = 15; board[2][1] = 15; board[6][4] = 15;
    @(negedge clk);
    matrizBombastic = packBoard();
    @(posedge clk);
    #1;
    checkVal("mixed_table", matrizNumeros, expMixed);
    checkVal("mixed_model", modelo(), expMixed);

    clearBoard(0);
    applyAndCheck("empty");
    checkVal("empty_const", matrizNumeros, 256'd0);
    clearBoard(15);
    applyAndCheck("full");
    checkVal("full_const", matrizNumeros, {64{4'hF}});

    clearBoard(0);
    board[3][3] = 15;
    applyAndCheck("single_3_3");
    checkVal("single_3_3_cell", 256'(matrizNumeros[2][2]), 256'd1);

    clearBoard(0);
    board[7][7] = 15;
    applyAndCheck("corner_7_7");
    checkVal("corner_nowrap", 256'({matrizNumeros[0][0], matrizNumeros[7][0], matrizNumeros[0][7]}), 256'd0);

    clearBoard(0);
    for (int dr = 3; dr <= 5; dr++)
      for (int dc = 3; dc <= 5; dc++)
        board[dr][dc] = 15;
    board[4][4] = 14;
    applyAndCheck("max_count");
    checkVal("max_count_cell", 256'(matrizNumeros[4][4]), 256'd8);

    // Latency: a mid-cycle input change does not reach the output before the next edge.
    clearBoard(0);
    board[1][1] = 15;
    applyAndCheck("latency_a");
    boardA = modelo();
    @(negedge clk);
    clearBoard(0);
    board[6][6] = 15;
    matrizBombastic = packBoard();
    #1;
    checkVal("latency_hold", matrizNumeros, boardA);
    @(posedge clk);
    #1;
    checkVal("latency_b", matrizNumeros, modelo());

    // Random boards with varying bomb density and non-bomb codes 0..14.
    for (int t = 0; t < 120; t++) begin
      int dens = $urandom_range(0, 100);
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          board[r][c] = ($urandom_range(0, 99) < dens) ? 15 : int'($urandom_range(0, 14));
      applyAndCheck("random");
    end

    // Asynchronous reset mid-cycle clears output with no clock edge.
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkVal("async_reset", matrizNumeros, 256'd0);
    @(posedge clk);
    #1;
    checkVal("async_reset_hold", matrizNumeros, 256'd0);
    @(negedge clk);
    rst = 1'b1;
    applyAndCheck("after_reset");

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
